hex_display_scanner: RTL



---
 rtl/hex_display_pkg.sv | 21 ++
 rtl/seven_seg_decoder.sv | 12 +
 rtl/hex_display_scanner.sv | 133 +++++++++++++
 3 files changed

// File: rtl/hex_display_pkg.sv
// Shared types and constants for the hex display scanner.
// Holds the scan phase enum, blanking constants and segment patterns.
package hex_display_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } phase_e;

  localparam logic [6:0] SEG_OFF    = 7'b1111111;
  localparam logic [7:0] DIGITS_OFF = 8'hFF;

  // Active-low patterns, bit 6 = g ... bit 0 = a; element 0 is hex 0.
  localparam logic [0:15][6:0] SEG_LUT = {
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational hex nibble to active-low seven-segment lookup.
// Sits on the single shared segment path of the scanner.
module seven_seg_decoder
  import hex_display_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_LUT[hex_i];

endmodule

// File: rtl/hex_display_scanner.sv
// Multiplexed seven-segment scanner with frame-aligned commit of a shadow word.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 always shown).
module hex_display_scanner
  import hex_display_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int PRESCALE   = 50000,
  parameter int GUARD      = 500
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic                    load,
  output logic                    update_pending,
  output logic                    frame_start,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic [6:0]              segments
);

  localparam int SW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW = 4 * NUM_DIGITS;

  logic [SW-1:0]         slot_q, slot_d;
  logic [IW-1:0]         idx_q, idx_d;
  phase_e                phase_q, phase_d;
  logic [DW-1:0]         shadow_q, shadow_d;
  logic [DW-1:0]         disp_q, disp_d;
  logic                  pending_q, pending_d;
  logic [NUM_DIGITS-1:0] digit_en_q, digit_en_d;
  logic [6:0]            segments_q, segments_d;
  logic                  frame_start_q, frame_start_d;

  logic                  last_slot, commit, drive;
  logic [3:0]            nib_d;
  logic [6:0]            seg_dec;
  logic [NUM_DIGITS-1:0] lz;

  always_comb begin
    slot_d    = slot_q + SW'(1);
    idx_d     = idx_q;
    phase_d   = phase_q;
    shadow_d  = shadow_q;
    disp_d    = disp_q;
    pending_d = pending_q;
    last_slot = (slot_q == SW'(PRESCALE - 1));
    commit    = last_slot && (idx_q == IW'(NUM_DIGITS - 1));

    if (phase_q == BLANK && slot_q == SW'(GUARD - 1))
      phase_d = DRIVE;
    if (last_slot) begin
      slot_d  = '0;
      phase_d = BLANK;
      idx_d   = commit ? '0 : idx_q + IW'(1);
    end

    if (load) begin
      shadow_d  = data_in;
      pending_d = 1'b1;
    end
    // A load landing on the commit edge bypasses the shadow entirely.
    if (commit) begin
      if (load)
        disp_d = data_in;
      else if (pending_q)
        disp_d = shadow_q;
      pending_d = 1'b0;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic zero_above;
  always_comb begin
    zero_above = 1'b1;
    lz         = '0;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      zero_above = zero_above && (disp_d[4*k +: 4] == 4'h0);
      lz[k]      = zero_above;
    end
  end
`else
  assign lz = '0;
`endif

  assign nib_d = disp_d[{idx_d, 2'b00} +: 4];

  seven_seg_decoder u_dec (
    .hex_i (nib_d),
    .seg_o (seg_dec)
  );

  // Outputs are computed from next state so they line up with the counters.
  always_comb begin
    drive         = (phase_d == DRIVE) && !lz[idx_d];
    digit_en_d    = DIGITS_OFF[NUM_DIGITS-1:0];
    segments_d    = SEG_OFF;
    frame_start_d = (idx_d == '0) && (slot_d == '0);
    if (drive) begin
      digit_en_d[idx_d] = 1'b0;
      segments_d        = seg_dec;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_q        <= '0;
      idx_q         <= '0;
      phase_q       <= BLANK;
      shadow_q      <= '0;
      disp_q        <= '0;
      pending_q     <= 1'b0;
      digit_en_q    <= DIGITS_OFF[NUM_DIGITS-1:0];
      segments_q    <= SEG_OFF;
      frame_start_q <= 1'b1;
    end else begin
      slot_q        <= slot_d;
      idx_q         <= idx_d;
      phase_q       <= phase_d;
      shadow_q      <= shadow_d;
      disp_q        <= disp_d;
      pending_q     <= pending_d;
      digit_en_q    <= digit_en_d;
      segments_q    <= segments_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign update_pending = pending_q;
  assign frame_start    = frame_start_q;
  assign digit_en       = digit_en_q;
  assign segments       = segments_q;

endmodule
